// File: rtl/multicycle_control_fsm.sv
// +----------------------------------------------------------------------------+
// | Module   : multicycle_control_fsm                                          |
// | Desc     : Main control FSM of the multicycle RV32I core. Sequences fetch, |
// |            decode, execute, memory and writeback and drives the datapath.  |
// | Config   : CTRL_JAL_EN - when defined, builds the JAL state               |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module multicycle_control_fsm #(
  parameter int OPCODE_W = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                adr_src,
  output logic                mem_write,
  output logic                ir_write,
  output logic [1:0]          result_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          imm_src,
  output logic                reg_write,
  output logic [1:0]          alu_op,
  output logic                illegal_instr
);

  localparam logic [OPCODE_W-1:0] c_OP_LW   = OPCODE_W'(7'b0000011);
  localparam logic [OPCODE_W-1:0] c_OP_SW   = OPCODE_W'(7'b0100011);
  localparam logic [OPCODE_W-1:0] c_OP_RTYP = OPCODE_W'(7'b0110011);
  localparam logic [OPCODE_W-1:0] c_OP_ITYP = OPCODE_W'(7'b0010011);
  localparam logic [OPCODE_W-1:0] c_OP_BEQ  = OPCODE_W'(7'b1100011);
  localparam logic [OPCODE_W-1:0] c_OP_JAL  = OPCODE_W'(7'b1101111);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9
`ifdef CTRL_JAL_EN
    ,
    S_JAL      = 4'd10
`endif
  } state_t;

  state_t r_state;
  state_t w_next_state;
  state_t w_eff_state;

  logic w_is_load;
  logic w_is_store;
  logic w_is_rtype;
  logic w_is_itype;
  logic w_is_beq;
  logic w_is_jal;
  logic w_legal;
  logic w_pc_update;
  logic w_branch;

  assign w_is_load  = (opcode == c_OP_LW);
  assign w_is_store = (opcode == c_OP_SW);
  assign w_is_rtype = (opcode == c_OP_RTYP);
  assign w_is_itype = (opcode == c_OP_ITYP);
  assign w_is_beq   = (opcode == c_OP_BEQ);
`ifdef CTRL_JAL_EN
  assign w_is_jal   = (opcode == c_OP_JAL);
`else
  assign w_is_jal   = 1'b0;
`endif
  assign w_legal = w_is_load | w_is_store | w_is_rtype | w_is_itype | w_is_beq | w_is_jal;

  // Immediate format follows the opcode directly, independent of the JAL build option.
  always_comb begin
    imm_src = 2'b00;
    if (opcode == c_OP_SW)       imm_src = 2'b01;
    else if (opcode == c_OP_BEQ) imm_src = 2'b10;
    else if (opcode == c_OP_JAL) imm_src = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:    if (mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        if (w_is_load | w_is_store) w_next_state = S_MEMADR;
        else if (w_is_rtype)        w_next_state = S_EXECR;
        else if (w_is_itype)        w_next_state = S_EXECI;
        else if (w_is_beq)          w_next_state = S_BEQ;
`ifdef CTRL_JAL_EN
        else if (w_is_jal)          w_next_state = S_JAL;
`endif
        else                        w_next_state = S_FETCH;
      end
      S_MEMADR: begin
        if (w_is_load)       w_next_state = S_MEMREAD;
        else if (w_is_store) w_next_state = S_MEMWRITE;
        else                 w_next_state = S_FETCH;
      end
      S_MEMREAD:  if (mem_ready) w_next_state = S_MEMWB;
      S_MEMWB:    w_next_state = S_FETCH;
      S_MEMWRITE: if (mem_ready) w_next_state = S_FETCH;
      S_EXECR:    w_next_state = S_ALUWB;
      S_EXECI:    w_next_state = S_ALUWB;
      S_ALUWB:    w_next_state = S_FETCH;
      S_BEQ:      w_next_state = S_FETCH;
`ifdef CTRL_JAL_EN
      S_JAL:      w_next_state = S_ALUWB;
`endif
      default:    w_next_state = S_FETCH;
    endcase
  end

  // While in reset the datapath sees FETCH selects with every enable held low.
  assign w_eff_state = rst_n ? r_state : S_FETCH;

  always_comb begin
    w_pc_update   = 1'b0;
    w_branch      = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    reg_write     = 1'b0;
    alu_op        = 2'b00;
    illegal_instr = 1'b0;
    case (w_eff_state)
      S_FETCH: begin
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        ir_write    = mem_ready;
        w_pc_update = mem_ready;
      end
      S_DECODE: begin
        alu_src_a     = 2'b01;
        alu_src_b     = 2'b01;
        illegal_instr = ~w_legal;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        w_branch  = 1'b1;
      end
`ifdef CTRL_JAL_EN
      S_JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        w_pc_update = 1'b1;
      end
`endif
      default: ;
    endcase
    pc_write = w_pc_update | (w_branch & zero);
    if (!rst_n) begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_multicycle_control_fsm                                       |
// | Desc     : Scoreboard bench for multicycle_control_fsm; instruction-level  |
// |            reference model expands each instruction into expected cycles.  |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_control_fsm;

  localparam logic [6:0] c_LW   = 7'b0000011;
  localparam logic [6:0] c_SW   = 7'b0100011;
  localparam logic [6:0] c_RTYP = 7'b0110011;
  localparam logic [6:0] c_ITYP = 7'b0010011;
  localparam logic [6:0] c_BEQ  = 7'b1100011;
  localparam logic [6:0] c_JAL  = 7'b1101111;

  typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                    P_EXECR, P_EXECI, P_ALUWB, P_BEQ, P_JAL} ph_e;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       illegal;
  } ctl_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, alu_op;

  multicycle_control_fsm #(.OPCODE_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .reg_write(reg_write), .alu_op(alu_op), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  ctl_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_idx;
  int   rst_at;
  bit   aborted;

  function automatic logic [1:0] imm_of(input logic [6:0] opc);
    case (opc)
      c_SW:    return 2'b01;
      c_BEQ:   return 2'b10;
      c_JAL:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  function automatic bit legal(input logic [6:0] opc);
`ifdef CTRL_JAL_EN
    if (opc == c_JAL) return 1'b1;
`endif
    return (opc == c_LW) || (opc == c_SW) || (opc == c_RTYP) ||
           (opc == c_ITYP) || (opc == c_BEQ);
  endfunction

  // Expected control word for one cycle of an instruction in a given phase.
  function automatic ctl_t expect_of(input ph_e ph, input logic mr, input logic z,
                                     input logic [6:0] opc, input bit in_rst);
    ctl_t e;
    e = '0;
    e.imm_src = imm_of(opc);
    if (in_rst) begin
      e.alu_src_b = 2'b10; e.result_src = 2'b10;
      return e;
    end
    case (ph)
      P_FETCH:    begin e.alu_src_b = 2'b10; e.result_src = 2'b10;
                        e.ir_write = mr; e.pc_write = mr; end
      P_DECODE:   begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; e.illegal = !legal(opc); end
      P_MEMADR:   begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
      P_MEMREAD:  begin e.adr_src = 1'b1; end
      P_MEMWB:    begin e.result_src = 2'b01; e.reg_write = 1'b1; end
      P_MEMWRITE: begin e.adr_src = 1'b1; e.mem_write = 1'b1; end
      P_EXECR:    begin e.alu_src_a = 2'b10; e.alu_op = 2'b10; end
      P_EXECI:    begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_op = 2'b10; end
      P_ALUWB:    begin e.reg_write = 1'b1; end
      P_BEQ:      begin e.alu_src_a = 2'b10; e.alu_op = 2'b01; e.pc_write = z; end
      P_JAL:      begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic reset_cycle();
    rst_n     = 1'b0;
    mem_ready = 1'($urandom);
    zero      = 1'($urandom);
    exp_q.push_back(expect_of(P_FETCH, mem_ready, zero, opcode, 1'b1));
    @(posedge clk); #1;
  endtask

  task automatic step(input ph_e ph, input logic mr, input logic z);
    if (aborted) return;
    if (cyc_idx == rst_at) begin
      aborted = 1'b1;
      reset_cycle();
    end else begin
      rst_n     = 1'b1;
      mem_ready = mr;
      zero      = z;
      exp_q.push_back(expect_of(ph, mr, z, opcode, 1'b0));
      @(posedge clk); #1;
    end
    cyc_idx++;
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Expands one instruction into its cycle sequence; rst_point<0 means no reset.
  task automatic run_instr(input logic [6:0] opc, input int fwait, input int mwait,
                           input logic zbeq, input int rst_point);
    opcode  = opc;
    cyc_idx = 0;
    rst_at  = rst_point;
    aborted = 1'b0;
    for (int i = 0; i < fwait; i++) step(P_FETCH, 1'b0, rb());
    step(P_FETCH, 1'b1, rb());
    step(P_DECODE, rb(), rb());
    if (!legal(opc)) return;
    case (opc)
      c_LW: begin
        step(P_MEMADR, rb(), rb());
        for (int i = 0; i < mwait; i++) step(P_MEMREAD, 1'b0, rb());
        step(P_MEMREAD, 1'b1, rb());
        step(P_MEMWB, rb(), rb());
      end
      c_SW: begin
        step(P_MEMADR, rb(), rb());
        for (int i = 0; i < mwait; i++) step(P_MEMWRITE, 1'b0, rb());
        step(P_MEMWRITE, 1'b1, rb());
      end
      c_RTYP: begin step(P_EXECR, rb(), rb()); step(P_ALUWB, rb(), rb()); end
      c_ITYP: begin step(P_EXECI, rb(), rb()); step(P_ALUWB, rb(), rb()); end
      c_BEQ:  step(P_BEQ, rb(), zbeq);
      c_JAL:  begin step(P_JAL, rb(), rb()); step(P_ALUWB, rb(), rb()); end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    ctl_t act, exp_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act = '{pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
              alu_src_b, imm_src, reg_write, alu_op, illegal_instr};
      n_cmp++;
      if (act !== exp_v) begin
        n_bad++;
        $display("FAIL ctl_word t=%0t opcode=%b rst_n=%b mem_ready=%b zero=%b: got %b required %b",
                 $time, opcode, rst_n, mem_ready, zero, act, exp_v);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] pool [6];
    logic [6:0] opc;
    int         rp;
    pool[0] = c_LW; pool[1] = c_SW; pool[2] = c_RTYP;
    pool[3] = c_ITYP; pool[4] = c_BEQ; pool[5] = c_JAL;
    rst_n = 1'b0; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    reset_cycle();
    reset_cycle();

    run_instr(c_RTYP, 0, 0, 1'b0, -1);
    run_instr(c_LW,   0, 2, 1'b0, -1);
    run_instr(c_SW,   0, 3, 1'b0, -1);
    run_instr(c_BEQ,  0, 0, 1'b1, -1);
    run_instr(c_BEQ,  0, 0, 1'b0, -1);
    run_instr(7'b0000000, 0, 0, 1'b0, -1);
    run_instr(c_JAL,  0, 0, 1'b0, -1);
    run_instr(c_ITYP, 1, 0, 1'b0, -1);
    run_instr(c_SW,   0, 3, 1'b0, 3);
    run_instr(c_LW,   2, 1, 1'b0, -1);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) opc = 7'($urandom);
      else                           opc = pool[$urandom_range(0, 5)];
      rp = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_instr(opc, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                1'($urandom), rp);
    end

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
